elastic_pipe: RTL and testbench

Parametrised valid/ready pipeline of `DEPTH` register stages, each `WIDTH` bits wide, for inserting retiming stages between blocks in the hierarchy. It generalises the single optional pass-through/FF cell:
- `DEPTH=0` is a pure wire.
- `DEPTH>=1` gives a bubble-collapsing elastic pipeline that honours back-pressure without losing or duplicating data.

Each instance sits between a producer and a consumer that both use the valid/ready handshake.

---
 rtl/elastic_pipe.sv | 130 +++++++++++++
 tb/tb_elastic_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe.sv
// -----------------------------------------------------------------------------
// elastic_pipe
//
// Parametrised valid/ready retiming pipeline of DEPTH register stages, each
// WIDTH bits wide. DEPTH=0 is a plain wire. DEPTH>=1 is a bubble-collapsing
// elastic pipeline: an empty stage always accepts, so a stalled consumer lets
// upstream words compact until every stage is full. No word is lost or
// duplicated and ordering is strictly first-in first-out.
//
// Optional feature macro: ELASTIC_PIPE_LEVEL_EN
//   When defined, the `level` output (number of occupied stages) and its
//   up/down counter are compiled in. When undefined, they are absent.
//
// Parameters:
//   WIDTH  data width in bits (>=1)
//   DEPTH  number of register stages (>=0, 0 = combinational pass-through)
//   LW     width of `level`, derived from DEPTH (minimum 1), not overridden
//
// Ports:
//   clk        single clock, all state updates on its rising edge
//   rst        synchronous active-high reset (ignored when DEPTH=0)
//   in_valid   producer has data
//   in_ready   pipeline accepts data this cycle
//   in_data    producer data
//   out_valid  last stage holds data
//   out_ready  consumer accepts data this cycle
//   out_data   data from the last stage
//   level      occupied stage count (only with ELASTIC_PIPE_LEVEL_EN)
// -----------------------------------------------------------------------------
module elastic_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter int LW    = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_LEVEL_EN
    ,
    output logic [LW-1:0]    level
`endif
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Pass-through build has no state, so clock and reset are unused.
            logic unused_s;
            assign unused_s  = clk ^ rst;

            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;
`ifdef ELASTIC_PIPE_LEVEL_EN
            assign level     = {LW{1'b0}};
`endif
        end else begin : g_pipe
            logic [DEPTH-1:0] v_r;
            logic [WIDTH-1:0] d_r [DEPTH];
            // rdy_s[i] = stage i may load this cycle; rdy_s[DEPTH] is the consumer.
            logic [DEPTH:0]   rdy_s;

            // Ready chain: a stage can load when it is empty or its successor
            // loads too. This is deliberately combinational across all stages.
            always_comb begin
                rdy_s        = {(DEPTH + 1){1'b0}};
                rdy_s[DEPTH] = out_ready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    rdy_s[i] = ~v_r[i] | rdy_s[i + 1];
                end
            end

            // Stage registers: each ready stage takes its predecessor's
            // contents (stage 0 takes the input), otherwise it holds.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= {DEPTH{1'b0}};
                    for (int i = 0; i < DEPTH; i++) begin
                        d_r[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    if (rdy_s[0]) begin
                        v_r[0] <= in_valid;
                        d_r[0] <= in_data;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        if (rdy_s[i]) begin
                            v_r[i] <= v_r[i - 1];
                            d_r[i] <= d_r[i - 1];
                        end
                    end
                end
            end

            assign in_ready  = rdy_s[0];
            assign out_valid = v_r[DEPTH - 1];
            assign out_data  = d_r[DEPTH - 1];

`ifdef ELASTIC_PIPE_LEVEL_EN
            logic          in_xfer_s;
            logic          out_xfer_s;
            logic [LW-1:0] level_r;

            assign in_xfer_s  = in_valid & rdy_s[0];
            assign out_xfer_s = v_r[DEPTH - 1] & out_ready;

            // Occupancy counter: a simultaneous input and output transfer
            // leaves the count unchanged.
            always_ff @(posedge clk) begin
                if (rst) begin
                    level_r <= {LW{1'b0}};
                end else begin
                    case ({in_xfer_s, out_xfer_s})
                        2'b10:   level_r <= level_r + LW'(1);
                        2'b01:   level_r <= level_r - LW'(1);
                        default: level_r <= level_r;
                    endcase
                end
            end

            assign level = level_r;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipe.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe
//
// Self-checking bench for elastic_pipe. Five instances cover the configurations
// exercised: DEPTH=3/WIDTH=8 (streaming, back-pressure), DEPTH=4/WIDTH=8
// (bubble collapse), DEPTH=2/WIDTH=8 (mid-operation reset), DEPTH=0/WIDTH=4
// (pass-through) and DEPTH=5/WIDTH=16 (random traffic against a queue model).
// The `level` checks are compiled only with ELASTIC_PIPE_LEVEL_EN.
//
// Reference model for random traffic: a queue of accepted words, each tagged
// with the edge index at which it was accepted. The head word is visible at the
// output once DEPTH-1 further edges have passed; the pipe refuses input only
// when it holds DEPTH words and the consumer is not ready.
// -----------------------------------------------------------------------------
module tb_elastic_pipe;

    localparam int P5_DEPTH = 5;

    logic clk_s = 1'b0;
    logic rst_s;
    int   tests_run;
    int   tests_failed;

    // Free-running clock, 10 time-unit period.
    always #5 clk_s = ~clk_s;

    // DEPTH=3, WIDTH=8
    logic       p3_in_valid_s, p3_in_ready_s, p3_out_valid_s, p3_out_ready_s;
    logic [7:0] p3_in_data_s, p3_out_data_s;
    // DEPTH=4, WIDTH=8
    logic       p4_in_valid_s, p4_in_ready_s, p4_out_valid_s, p4_out_ready_s;
    logic [7:0] p4_in_data_s, p4_out_data_s;
    // DEPTH=2, WIDTH=8
    logic       p2_in_valid_s, p2_in_ready_s, p2_out_valid_s, p2_out_ready_s;
    logic [7:0] p2_in_data_s, p2_out_data_s;
    // DEPTH=0, WIDTH=4
    logic       p0_in_valid_s, p0_in_ready_s, p0_out_valid_s, p0_out_ready_s;
    logic [3:0] p0_in_data_s, p0_out_data_s;
    // DEPTH=5, WIDTH=16
    logic        p5_in_valid_s, p5_in_ready_s, p5_out_valid_s, p5_out_ready_s;
    logic [15:0] p5_in_data_s, p5_out_data_s;
`ifdef ELASTIC_PIPE_LEVEL_EN
    logic [1:0] p3_level_s;
    logic [2:0] p4_level_s;
    logic [1:0] p2_level_s;
    logic [0:0] p0_level_s;
    logic [2:0] p5_level_s;
`endif

    elastic_pipe #(.WIDTH(8), .DEPTH(3)) u_p3 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(p3_in_valid_s), .in_ready(p3_in_ready_s), .in_data(p3_in_data_s),
        .out_valid(p3_out_valid_s), .out_ready(p3_out_ready_s), .out_data(p3_out_data_s)
`ifdef ELASTIC_PIPE_LEVEL_EN
        , .level(p3_level_s)
`endif
    );

    elastic_pipe #(.WIDTH(8), .DEPTH(4)) u_p4 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(p4_in_valid_s), .in_ready(p4_in_ready_s), .in_data(p4_in_data_s),
        .out_valid(p4_out_valid_s), .out_ready(p4_out_ready_s), .out_data(p4_out_data_s)
`ifdef ELASTIC_PIPE_LEVEL_EN
        , .level(p4_level_s)
`endif
    );

    elastic_pipe #(.WIDTH(8), .DEPTH(2)) u_p2 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(p2_in_valid_s), .in_ready(p2_in_ready_s), .in_data(p2_in_data_s),
        .out_valid(p2_out_valid_s), .out_ready(p2_out_ready_s), .out_data(p2_out_data_s)
`ifdef ELASTIC_PIPE_LEVEL_EN
        , .level(p2_level_s)
`endif
    );

    elastic_pipe #(.WIDTH(4), .DEPTH(0)) u_p0 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(p0_in_valid_s), .in_ready(p0_in_ready_s), .in_data(p0_in_data_s),
        .out_valid(p0_out_valid_s), .out_ready(p0_out_ready_s), .out_data(p0_out_data_s)
`ifdef ELASTIC_PIPE_LEVEL_EN
        , .level(p0_level_s)
`endif
    );

    elastic_pipe #(.WIDTH(16), .DEPTH(P5_DEPTH)) u_p5 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(p5_in_valid_s), .in_ready(p5_in_ready_s), .in_data(p5_in_data_s),
        .out_valid(p5_out_valid_s), .out_ready(p5_out_ready_s), .out_data(p5_out_data_s)
`ifdef ELASTIC_PIPE_LEVEL_EN
        , .level(p5_level_s)
`endif
    );

    // Back-pressure fill on DEPTH=3: stimulus and expected values per cycle.
    int bp_iv  [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int bp_din [11] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA3, 'hA3, 0, 0, 0, 0, 0};
    int bp_or  [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1};
    int bp_rdy [11] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1};
    int bp_v   [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int bp_d   [11] = '{0, 0, 0, 'hA0, 'hA0, 'hA0, 'hA1, 'hA1, 'hA2, 'hA3, 0};
    int bp_lvl [11] = '{0, 1, 2, 3, 3, 3, 3, 3, 2, 1, 0};

    // Bubble collapse on DEPTH=4: stimulus and expected values per cycle.
    int bb_iv  [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    int bb_din [9] = '{'h11, 0, 'h22, 0, 0, 0, 0, 0, 0};
    int bb_or  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int bb_v   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int bb_d   [9] = '{0, 0, 0, 0, 'h11, 'h11, 'h11, 'h22, 0};
    int bb_lvl [9] = '{0, 1, 1, 2, 2, 2, 2, 1, 0};

    // Random-traffic reference model state.
    logic [15:0] q_data [$];
    int          q_edge [$];
    int          edge_idx;
    int          in_bias;
    int          out_bias;
    logic        exp_valid;
    logic        exp_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Directed steps followed by random traffic against the queue model.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_s        = 1'b1;
        {p3_in_valid_s, p3_out_ready_s, p3_in_data_s} = 10'd0;
        {p4_in_valid_s, p4_out_ready_s, p4_in_data_s} = 10'd0;
        {p2_in_valid_s, p2_out_ready_s, p2_in_data_s} = 10'd0;
        {p0_in_valid_s, p0_out_ready_s, p0_in_data_s} = 6'd0;
        {p5_in_valid_s, p5_out_ready_s, p5_in_data_s} = 18'd0;
        tick();
        tick();

        // ---- reset state ----
        rst_s = 1'b0;
        #1;
        check("rst_out_valid", 32'(p3_out_valid_s), 32'd0);
        check("rst_out_data", 32'(p3_out_data_s), 32'd0);
        check("rst_in_ready", 32'(p3_in_ready_s), 32'd1);
        check("rst_out_valid_d5", 32'(p5_out_valid_s), 32'd0);
`ifdef ELASTIC_PIPE_LEVEL_EN
        check("rst_level", 32'(p3_level_s), 32'd0);
`endif
        tick();

        // ---- streaming 0x01..0x0A through DEPTH=3 with out_ready=1 ----
        p3_out_ready_s = 1'b1;
        for (int c = 0; c < 14; c++) begin
            p3_in_valid_s = (c < 10);
            p3_in_data_s  = 8'(c + 1);
            #1;
            check("stream_in_ready", 32'(p3_in_ready_s), 32'd1);
            check("stream_out_valid", 32'(p3_out_valid_s), 32'((c >= 3) && (c < 13)));
            if ((c >= 3) && (c < 13)) begin
                check("stream_out_data", 32'(p3_out_data_s), 32'(c - 2));
            end
`ifdef ELASTIC_PIPE_LEVEL_EN
            check("stream_level", 32'(p3_level_s),
                  32'(((c < 10) ? c : 10) - ((c > 3) ? (((c < 13) ? c : 13) - 3) : 0)));
`endif
            tick();
        end

        // ---- back-pressure fill on DEPTH=3 ----
        for (int c = 0; c < 11; c++) begin
            p3_in_valid_s  = 1'(bp_iv[c]);
            p3_in_data_s   = 8'(bp_din[c]);
            p3_out_ready_s = 1'(bp_or[c]);
            #1;
            check("bp_in_ready", 32'(p3_in_ready_s), 32'(bp_rdy[c]));
            check("bp_out_valid", 32'(p3_out_valid_s), 32'(bp_v[c]));
            if (bp_v[c] == 1) begin
                check("bp_out_data", 32'(p3_out_data_s), 32'(bp_d[c]));
            end
`ifdef ELASTIC_PIPE_LEVEL_EN
            check("bp_level", 32'(p3_level_s), 32'(bp_lvl[c]));
`endif
            tick();
        end
        p3_out_ready_s = 1'b0;

        // ---- bubble collapse on DEPTH=4 ----
        for (int c = 0; c < 9; c++) begin
            p4_in_valid_s  = 1'(bb_iv[c]);
            p4_in_data_s   = 8'(bb_din[c]);
            p4_out_ready_s = 1'(bb_or[c]);
            #1;
            check("bubble_in_ready", 32'(p4_in_ready_s), 32'd1);
            check("bubble_out_valid", 32'(p4_out_valid_s), 32'(bb_v[c]));
            if (bb_v[c] == 1) begin
                check("bubble_out_data", 32'(p4_out_data_s), 32'(bb_d[c]));
            end
`ifdef ELASTIC_PIPE_LEVEL_EN
            check("bubble_level", 32'(p4_level_s), 32'(bb_lvl[c]));
`endif
            tick();
        end
        p4_out_ready_s = 1'b0;

        // ---- mid-operation reset on DEPTH=2 ----
        p2_in_valid_s = 1'b1;
        p2_in_data_s  = 8'h55;
        #1;
        check("mrst_accept0", 32'(p2_in_ready_s), 32'd1);
        tick();
        p2_in_data_s = 8'h66;
        #1;
        check("mrst_accept1", 32'(p2_in_ready_s), 32'd1);
        tick();
        p2_in_valid_s  = 1'b0;
        p2_in_data_s   = 8'h00;
        p2_out_ready_s = 1'b1;
        rst_s          = 1'b1;
        #1;
        check("mrst_pre_valid", 32'(p2_out_valid_s), 32'd1);
        check("mrst_pre_data", 32'(p2_out_data_s), 32'h55);
        tick();
        rst_s = 1'b0;
        #1;
        check("mrst_post_valid", 32'(p2_out_valid_s), 32'd0);
        check("mrst_post_data", 32'(p2_out_data_s), 32'd0);
        check("mrst_post_ready", 32'(p2_in_ready_s), 32'd1);
`ifdef ELASTIC_PIPE_LEVEL_EN
        check("mrst_post_level", 32'(p2_level_s), 32'd0);
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mrst_never_out", 32'(p2_out_valid_s), 32'd0);
        end
        p2_out_ready_s = 1'b0;

        // ---- DEPTH=0 pass-through, reset toggled too ----
        for (int n = 0; n < 40; n++) begin
            p0_in_valid_s  = 1'($urandom_range(0, 1));
            p0_in_data_s   = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'hC;
            p0_out_ready_s = 1'($urandom_range(0, 1));
            rst_s          = 1'($urandom_range(0, 1));
            #1;
            check("wire_out_valid", 32'(p0_out_valid_s), 32'(p0_in_valid_s));
            check("wire_out_data", 32'(p0_out_data_s), 32'(p0_in_data_s));
            check("wire_in_ready", 32'(p0_in_ready_s), 32'(p0_out_ready_s));
`ifdef ELASTIC_PIPE_LEVEL_EN
            check("wire_level", 32'(p0_level_s), 32'd0);
`endif
            tick();
        end
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;

        // ---- random traffic on DEPTH=5 against the queue model ----
        edge_idx = 0;
        in_bias  = 60;
        out_bias = 50;
        for (int n = 0; n < 10000; n++) begin
            if ((n % 500) == 0) begin
                in_bias  = 30 + 30 * int'($urandom_range(0, 2));
                out_bias = 10 + 40 * int'($urandom_range(0, 2));
            end
            rst_s          = ($urandom_range(0, 699) == 0);
            p5_in_valid_s  = (int'($urandom_range(0, 99)) < in_bias);
            p5_in_data_s   = 16'($urandom);
            p5_out_ready_s = (int'($urandom_range(0, 99)) < out_bias);
            #1;
            exp_valid = 1'b0;
            if (q_data.size() > 0) begin
                exp_valid = ((edge_idx - q_edge[0]) >= P5_DEPTH);
            end
            exp_ready = !((q_data.size() == P5_DEPTH) && !p5_out_ready_s);
            check("rand_out_valid", 32'(p5_out_valid_s), 32'(exp_valid));
            check("rand_in_ready", 32'(p5_in_ready_s), 32'(exp_ready));
            if (exp_valid) begin
                check("rand_out_data", 32'(p5_out_data_s), 32'(q_data[0]));
            end
`ifdef ELASTIC_PIPE_LEVEL_EN
            check("rand_level", 32'(p5_level_s), 32'(q_data.size()));
`endif
            if (rst_s) begin
                q_data.delete();
                q_edge.delete();
            end else begin
                if (exp_valid && p5_out_ready_s) begin
                    void'(q_data.pop_front());
                    void'(q_edge.pop_front());
                end
                if (p5_in_valid_s && exp_ready) begin
                    q_data.push_back(p5_in_data_s);
                    q_edge.push_back(edge_idx);
                end
            end
            tick();
            edge_idx++;
        end
        rst_s = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
